// File: rtl/flow_cam_pkg.sv
// ----------------------------------------------------------------------------
// flow_cam_pkg
// Shared definitions for the camera capture path, the frame store and the flow
// core: frame size, luma coefficients, capture state encoding and the RGB565
// pixel payload.
// ----------------------------------------------------------------------------
package flow_cam_pkg;

    // Beats per frame expected by the frame store (14-bit pixel counter).
    localparam int unsigned FRAME_PIXELS = 16384;

    // Luma weights, sum to 256 so full white maps to 255 after >>8.
    localparam int unsigned COEF_R = 77;
    localparam int unsigned COEF_G = 150;
    localparam int unsigned COEF_B = 29;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRAME = 2'd1,
        PAD   = 2'd2,
        DONE  = 2'd3
    } cap_state_e;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

endpackage

// File: rtl/dvp_frame_capture_if.sv
// ----------------------------------------------------------------------------
// dvp_frame_capture_if
// Bundles the raw DVP camera pins with the grey-pixel stream to the frame
// store.
//   cam_pclk/cam_vsync/cam_href/cam_d : camera side (async to clk)
//   pixel_data/pixel_valid            : one grey pixel per valid strobe
//   frame_start/frame_done/frame_err  : per-frame framing pulses
// Modports: slave = the capture block, master = the environment around it.
// ----------------------------------------------------------------------------
interface dvp_frame_capture_if;

    logic       cam_pclk;
    logic       cam_vsync;
    logic       cam_href;
    logic [7:0] cam_d;
    logic [7:0] pixel_data;
    logic       pixel_valid;
    logic       frame_start;
    logic       frame_done;
    logic       frame_err;

    modport slave (
        input  cam_pclk, cam_vsync, cam_href, cam_d,
        output pixel_data, pixel_valid, frame_start, frame_done, frame_err
    );

    modport master (
        output cam_pclk, cam_vsync, cam_href, cam_d,
        input  pixel_data, pixel_valid, frame_start, frame_done, frame_err
    );

endinterface

// File: rtl/rgb565_to_gray.sv
// ----------------------------------------------------------------------------
// rgb565_to_gray
// One-stage registered RGB565 -> 8-bit luma. Channels are widened to 8 bits by
// replicating their MSBs, then weighted 77/150/29 and divided by 256
// (truncating).
//   clk, reset : clock, synchronous active-high reset
//   i_valid    : input pixel strobe
//   i_pix      : RGB565 pixel
//   o_valid    : i_valid delayed one clk
//   o_gray     : luma of the pixel presented with o_valid
// ----------------------------------------------------------------------------
module rgb565_to_gray
    import flow_cam_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_valid,
    input  rgb565_t    i_pix,
    output logic       o_valid,
    output logic [7:0] o_gray
);

    logic [7:0]  w_r8;
    logic [7:0]  w_g8;
    logic [7:0]  w_b8;
    logic [15:0] w_sum;
    logic        r_valid;
    logic [7:0]  r_gray;

    // Weighted sum peaks at 256*255, so 16 bits never overflow.
    always_comb begin
        w_r8  = {i_pix.r, i_pix.r[4:2]};
        w_g8  = {i_pix.g, i_pix.g[5:4]};
        w_b8  = {i_pix.b, i_pix.b[4:2]};
        w_sum = 16'(COEF_R) * 16'(w_r8)
              + 16'(COEF_G) * 16'(w_g8)
              + 16'(COEF_B) * 16'(w_b8);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_gray  <= 8'd0;
        end else begin
            r_valid <= i_valid;
            r_gray  <= w_sum[15:8];
        end
    end

    assign o_valid = r_valid;
    assign o_gray  = r_gray;

endmodule

// File: rtl/dvp_frame_capture.sv
// ----------------------------------------------------------------------------
// dvp_frame_capture
// Samples a DVP camera (RGB565, two bytes per pixel), converts to grey, crops
// and decimates to an OUT_W x OUT_H window and always delivers exactly
// OUT_W*OUT_H beats per captured frame (short frames are padded with zeros).
//   clk, reset : system clock (>= 4x cam_pclk), synchronous active-high reset
//   i_enable   : capture enable, only looked at on a vsync falling edge
//   bus        : camera inputs and pixel/framing outputs (slave modport)
// ----------------------------------------------------------------------------
module dvp_frame_capture
    import flow_cam_pkg::*;
#(
    parameter int unsigned SRC_W = 640,
    parameter int unsigned SRC_H = 480,
    parameter int unsigned OUT_W = 128,
    parameter int unsigned OUT_H = 128,
    parameter int unsigned DEC   = 2,
    parameter int unsigned X_OFF = 192,
    parameter int unsigned Y_OFF = 112
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_enable,
    dvp_frame_capture_if.slave bus
);

    localparam int unsigned X_END   = X_OFF + OUT_W * DEC;
    localparam int unsigned Y_END   = Y_OFF + OUT_H * DEC;
    localparam int unsigned FRAME_N = OUT_W * OUT_H;
    localparam int unsigned CNT_W   = $clog2(FRAME_N + 1);
    localparam int unsigned CW      = $clog2(((SRC_W > X_END) ? SRC_W : X_END) + 1);
    localparam int unsigned LW      = $clog2(((SRC_H > Y_END) ? SRC_H : Y_END) + 1);
    localparam int unsigned PW      = (DEC > 1) ? $clog2(DEC) : 1;

    // Two-stage synchronisers plus one history stage for edge detection.
    logic       r_pclk_s1, r_pclk_s2, r_pclk_d;
    logic       r_vs_s1, r_vs_s2, r_vs_d;
    logic       r_hr_s1, r_hr_s2, r_hr_d;
    logic [7:0] r_d_s1, r_d_s2;

    logic          r_phase;
    logic [7:0]    r_hi;
    logic [CW-1:0] r_col;
    logic [LW-1:0] r_line;
    logic [PW-1:0] r_xph;
    logic [PW-1:0] r_yph;

    cap_state_e       r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_started;
    logic [7:0]       r_pixel_data;
    logic             r_pixel_valid;
    logic             r_frame_start;
    logic             r_frame_done;
    logic             r_frame_err;

    logic       w_pclk_rise, w_vs_fall, w_vs_rise, w_hr_fall;
    logic       w_byte, w_col_in, w_line_in, w_keep, w_beat;
    rgb565_t    w_pix;
    logic       w_conv_valid;
    logic [7:0] w_conv_gray;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pclk_s1 <= 1'b0; r_pclk_s2 <= 1'b0; r_pclk_d <= 1'b0;
            r_vs_s1   <= 1'b0; r_vs_s2   <= 1'b0; r_vs_d   <= 1'b0;
            r_hr_s1   <= 1'b0; r_hr_s2   <= 1'b0; r_hr_d   <= 1'b0;
            r_d_s1    <= 8'd0; r_d_s2    <= 8'd0;
        end else begin
            r_pclk_s1 <= bus.cam_pclk;  r_pclk_s2 <= r_pclk_s1; r_pclk_d <= r_pclk_s2;
            r_vs_s1   <= bus.cam_vsync; r_vs_s2   <= r_vs_s1;   r_vs_d   <= r_vs_s2;
            r_hr_s1   <= bus.cam_href;  r_hr_s2   <= r_hr_s1;   r_hr_d   <= r_hr_s2;
            r_d_s1    <= bus.cam_d;     r_d_s2    <= r_d_s1;
        end
    end

    assign w_pclk_rise = r_pclk_s2 & ~r_pclk_d;
    assign w_vs_fall   = r_vs_d & ~r_vs_s2;
    assign w_vs_rise   = ~r_vs_d & r_vs_s2;
    assign w_hr_fall   = r_hr_d & ~r_hr_s2;
    assign w_byte      = w_pclk_rise & r_hr_s2;

    assign w_col_in  = (r_col >= CW'(X_OFF)) && (r_col < CW'(X_END));
    assign w_line_in = (r_line >= LW'(Y_OFF)) && (r_line < LW'(Y_END));
    assign w_pix     = rgb565_t'({r_hi, r_d_s2});

    // Low byte of a pixel on a decimation grid point inside the window.
    assign w_keep = w_byte && r_phase && w_col_in && w_line_in
                 && (r_xph == '0) && (r_yph == '0) && (r_state == FRAME);

    // Byte pairing plus column/line position; counters saturate at the window
    // end so oversize lines and frames never wrap back into the window.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase <= 1'b0;
            r_hi    <= 8'd0;
            r_col   <= '0;
            r_line  <= '0;
            r_xph   <= '0;
            r_yph   <= '0;
        end else begin
            if (w_vs_fall) begin
                r_line <= '0;
                r_yph  <= '0;
            end else if (w_hr_fall) begin
                if (w_line_in)
                    r_yph <= (r_yph == PW'(DEC - 1)) ? '0 : r_yph + PW'(1);
                if (r_line != LW'(Y_END))
                    r_line <= r_line + LW'(1);
            end

            if (w_vs_fall || w_hr_fall) begin
                r_phase <= 1'b0;
                r_col   <= '0;
                r_xph   <= '0;
            end else if (w_byte) begin
                r_phase <= ~r_phase;
                if (!r_phase) begin
                    r_hi <= r_d_s2;
                end else begin
                    if (w_col_in)
                        r_xph <= (r_xph == PW'(DEC - 1)) ? '0 : r_xph + PW'(1);
                    if (r_col != CW'(X_END))
                        r_col <= r_col + CW'(1);
                end
            end
        end
    end

    rgb565_to_gray u_gray (
        .clk     (clk),
        .reset   (reset),
        .i_valid (w_keep),
        .i_pix   (w_pix),
        .o_valid (w_conv_valid),
        .o_gray  (w_conv_gray)
    );

    assign w_beat = w_conv_valid && (r_count != CNT_W'(FRAME_N));

    // Frame sequencing and the output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_count       <= '0;
            r_started     <= 1'b0;
            r_pixel_data  <= 8'd0;
            r_pixel_valid <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_pixel_data  <= 8'd0;
            r_pixel_valid <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_count   <= '0;
                    r_started <= 1'b0;
                    if (w_vs_fall && i_enable)
                        r_state <= FRAME;
                end
                FRAME: begin
                    // Kept pixel reaches the output two clks later, so the
                    // start pulse registered now leads it by exactly one.
                    if (w_keep && !r_started) begin
                        r_frame_start <= 1'b1;
                        r_started     <= 1'b1;
                    end
                    if (w_beat) begin
                        r_pixel_valid <= 1'b1;
                        r_pixel_data  <= w_conv_gray;
                        r_count       <= r_count + CNT_W'(1);
                        if (r_count == CNT_W'(FRAME_N - 1))
                            r_frame_done <= 1'b1;
                    end
                    if (w_vs_rise) begin
                        if ((r_count == CNT_W'(FRAME_N)) ||
                            (w_beat && (r_count == CNT_W'(FRAME_N - 1)))) begin
                            r_state <= DONE;
                        end else begin
                            r_state <= PAD;
                            if (!r_started) begin
                                r_frame_start <= 1'b1;
                                r_started     <= 1'b1;
                            end
                        end
                    end
                end
                PAD: begin
                    r_pixel_valid <= 1'b1;
                    r_count       <= r_count + CNT_W'(1);
                    if (r_count == CNT_W'(FRAME_N - 1)) begin
                        r_frame_done <= 1'b1;
                        r_frame_err  <= 1'b1;
                        r_state      <= DONE;
                    end
                end
                DONE: begin
                    r_count   <= '0;
                    r_started <= 1'b0;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.pixel_data  = r_pixel_data;
    assign bus.pixel_valid = r_pixel_valid;
    assign bus.frame_start = r_frame_start;
    assign bus.frame_done  = r_frame_done;
    assign bus.frame_err   = r_frame_err;

endmodule

// File: tb/tb_dvp_frame_capture.sv
// ----------------------------------------------------------------------------
// tb_dvp_frame_capture
// Drives a scaled-down camera (24x16 source, 8x4 output window) and checks the
// grey pixel stream and framing pulses against an image-level model.
// ----------------------------------------------------------------------------
module tb_dvp_frame_capture;

    localparam int unsigned SRC_W = 24;
    localparam int unsigned SRC_H = 16;
    localparam int unsigned OUT_W = 8;
    localparam int unsigned OUT_H = 4;
    localparam int unsigned DEC   = 2;
    localparam int unsigned X_OFF = 4;
    localparam int unsigned Y_OFF = 3;
    localparam int          NPIX  = OUT_W * OUT_H;

    logic clk = 1'b0;
    logic reset;
    logic enable;

    always #5 clk = ~clk;

    dvp_frame_capture_if bus ();

    dvp_frame_capture #(
        .SRC_W (SRC_W), .SRC_H (SRC_H), .OUT_W (OUT_W), .OUT_H (OUT_H),
        .DEC   (DEC),   .X_OFF (X_OFF), .Y_OFF (Y_OFF)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .i_enable (enable),
        .bus      (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] img [SRC_H][SRC_W];
    logic [7:0]  expq [$];

    // Output monitor
    logic       mon_clr = 1'b0;
    logic [7:0] got [$];
    int beats, starts, start_bad, dones, done_beat, errs, err_alone;
    logic prev_start;

    always @(negedge clk) begin
        if (mon_clr) begin
            got.delete();
            beats = 0; starts = 0; start_bad = 0; dones = 0;
            done_beat = -1; errs = 0; err_alone = 0;
        end else begin
            if (bus.pixel_valid) begin
                if (beats == 0 && !prev_start) start_bad++;
                got.push_back(bus.pixel_data);
                beats++;
            end
            if (bus.frame_start) starts++;
            if (bus.frame_done) begin
                dones++;
                done_beat = bus.pixel_valid ? beats : -1;
            end
            if (bus.frame_err) begin
                errs++;
                if (!bus.frame_done) err_alone++;
            end
        end
        prev_start = bus.frame_start;
    end

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
    endtask

    // Luma from the bit-replication and weighting rules, plain integer maths.
    function automatic int grey(input logic [15:0] p);
        int r, g, b;
        r = int'(p[15:11]);
        g = int'(p[10:5]);
        b = int'(p[4:0]);
        r = (r << 3) | (r >> 2);
        g = (g << 2) | (g >> 4);
        b = (b << 3) | (b >> 2);
        return (77 * r + 150 * g + 29 * b) / 256;
    endfunction

    // mode 0: random, 1: constant, 2: column ramp (r=col, g=2*col, b=col)
    task automatic build(input int mode, input logic [15:0] cval);
        for (int l = 0; l < int'(SRC_H); l++)
            for (int c = 0; c < int'(SRC_W); c++)
                case (mode)
                    0:       img[l][c] = 16'($urandom);
                    1:       img[l][c] = cval;
                    default: img[l][c] = 16'(c) * 16'h0841;
                endcase
    endtask

    // Expected output: decimated window of the image, zeros past the last line sent.
    task automatic make_exp(input int nlines);
        int sy, sx;
        expq.delete();
        for (int oy = 0; oy < int'(OUT_H); oy++)
            for (int ox = 0; ox < int'(OUT_W); ox++) begin
                sy = int'(Y_OFF) + int'(DEC) * oy;
                sx = int'(X_OFF) + int'(DEC) * ox;
                expq.push_back((sy < nlines) ? 8'(grey(img[sy][sx])) : 8'd0);
            end
    endtask

    // One camera byte period: data changes while pclk is low, 4 clk per pclk.
    task automatic pc(input logic h, input logic [7:0] d);
        bus.cam_pclk = 1'b0;
        bus.cam_href = h;
        bus.cam_d    = d;
        repeat (2) @(negedge clk);
        bus.cam_pclk = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_frame(input int nlines);
        bus.cam_vsync = 1'b1;
        repeat (4) pc(1'b0, 8'h00);
        bus.cam_vsync = 1'b0;
        repeat (4) pc(1'b0, 8'h00);
        for (int l = 0; l < nlines; l++) begin
            repeat (2) pc(1'b0, 8'h00);
            for (int c = 0; c < int'(SRC_W); c++) begin
                pc(1'b1, img[l][c][15:8]);
                pc(1'b1, img[l][c][7:0]);
            end
        end
        repeat (2) pc(1'b0, 8'h00);
        bus.cam_vsync = 1'b1;
        repeat (12) pc(1'b0, 8'h00);
    endtask

    task automatic check_frame(input string nm, input int req_err);
        int bad = 0;
        int first = -1;
        for (int i = 0; i < NPIX; i++)
            if (i >= got.size() || got[i] !== expq[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        chk({nm, "_beats"}, beats, NPIX);
        chk({nm, "_data_bad"}, bad, 0);
        if (bad != 0 && first < got.size())
            $display("  %s first diff at %0d: got %02h want %02h", nm, first, got[first], expq[first]);
        chk({nm, "_starts"}, starts, 1);
        chk({nm, "_start_lead"}, start_bad, 0);
        chk({nm, "_dones"}, dones, 1);
        chk({nm, "_done_beat"}, done_beat, NPIX);
        chk({nm, "_errs"}, errs, req_err);
        chk({nm, "_err_alone"}, err_alone, 0);
    endtask

    task automatic check_quiet(input string nm);
        chk({nm, "_valid"}, int'(bus.pixel_valid), 0);
        chk({nm, "_data"},  int'(bus.pixel_data), 0);
        chk({nm, "_start"}, int'(bus.frame_start), 0);
        chk({nm, "_done"},  int'(bus.frame_done), 0);
        chk({nm, "_err"},   int'(bus.frame_err), 0);
    endtask

    task automatic wait_beats(input string nm, input int n);
        int t = 0;
        while (beats < n && t < 20000) begin
            @(negedge clk);
            t++;
        end
        chk({nm, "_reached"}, int'(beats >= n), 1);
    endtask

    typedef struct {
        logic [15:0] pix;
        logic [7:0]  req;
    } vec_t;

    vec_t vt [5];

    initial begin
        vt[0] = '{16'hFFFF, 8'hFF};
        vt[1] = '{16'h07E0, 8'h95};
        vt[2] = '{16'h001F, 8'h1C};
        vt[3] = '{16'hF800, 8'h4C};
        vt[4] = '{16'h0000, 8'h00};

        reset = 1'b1;
        enable = 1'b1;
        bus.cam_pclk = 1'b0; bus.cam_vsync = 1'b1; bus.cam_href = 1'b0; bus.cam_d = 8'h00;
        repeat (3) @(negedge clk);
        check_quiet("reset");
        reset = 1'b0;
        clear_mon();

        // Random frame with red at the window origin
        build(0, 16'h0);
        img[Y_OFF][X_OFF] = 16'hF800;
        make_exp(SRC_H);
        send_frame(SRC_H);
        chk("rand_first_px", (got.size() > 0) ? int'(got[0]) : -1, 'h4C);
        check_frame("rand", 0);

        // Constant-colour frames from the table
        for (int i = 0; i < 5; i++) begin
            int bad = 0;
            clear_mon();
            build(1, vt[i].pix);
            send_frame(SRC_H);
            for (int k = 0; k < got.size(); k++)
                if (got[k] !== vt[i].req) bad++;
            chk($sformatf("const%0d_beats", i), beats, NPIX);
            chk($sformatf("const%0d_bad_px", i), bad, 0);
            chk($sformatf("const%0d_dones", i), dones, 1);
        end

        // Column ramp: output x must come from source column X_OFF+2x
        clear_mon();
        build(2, 16'h0);
        make_exp(SRC_H);
        send_frame(SRC_H);
        check_frame("ramp", 0);

        // Frame cut short after 6 lines: padded with zeros, error flagged
        clear_mon();
        build(0, 16'h0);
        make_exp(6);
        send_frame(6);
        check_frame("cut", 1);

        // Reset mid-frame
        clear_mon();
        build(0, 16'h0);
        fork
            send_frame(SRC_H);
            begin
                wait_beats("rst", 10);
                reset = 1'b1;
                @(negedge clk);
                check_quiet("midrst");
                reset = 1'b0;
            end
        join
        chk("midrst_beats", beats, 10);
        clear_mon();
        build(0, 16'h0);
        make_exp(SRC_H);
        send_frame(SRC_H);
        check_frame("post_rst", 0);

        // Enable dropped mid-frame: frame completes, next frame silent
        clear_mon();
        build(0, 16'h0);
        make_exp(SRC_H);
        fork
            send_frame(SRC_H);
            begin
                wait_beats("en", 10);
                enable = 1'b0;
            end
        join
        check_frame("en_drop", 0);
        clear_mon();
        build(0, 16'h0);
        send_frame(SRC_H);
        chk("en_off_beats", beats, 0);
        chk("en_off_starts", starts, 0);

        clear_mon();
        enable = 1'b1;
        build(0, 16'h0);
        make_exp(SRC_H);
        send_frame(SRC_H);
        check_frame("re_en", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
